// File: rtl/cla_pipe_adder_if.sv
// Stream bundle for cla_pipe_adder: operand beat in, result beat out, valid/ready on each side.
// master = operand producer plus result consumer; slave = the adder.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: STAGES registered slices of 4-bit lookahead groups.
// Optional CLA_PIPE_FLAGS_EN computes ovf/zero; without it both outputs are tied to 0.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Operand bits still to be added when entering this stage.
    localparam int IW = WIDTH - gi * SW;

    logic [IW-1:0]         w_a;
    logic [IW-1:0]         w_b;
    logic                  w_c;
    logic                  w_v;
    logic                  w_ld;
    logic [SW-1:0]         w_p;
    logic [SW-1:0]         w_g;
    logic [SW-1:0]         w_bc;
    logic [SW-1:0]         w_s;
    logic [NG-1:0]         w_gp;
    logic [NG-1:0]         w_gg;
    logic [NG:0]           w_gc;
    logic [(gi+1)*SW-1:0]  w_sum_nx;
    logic [(gi+1)*SW-1:0]  r_sum;
    logic                  r_v;
    logic                  r_c;

    if (gi == 0) begin : g_in
      assign w_a      = bus.a;
      assign w_b      = bus.sub ? ~bus.b : bus.b;
      assign w_c      = bus.sub ^ bus.cin;
      assign w_v      = bus.in_valid;
      assign w_sum_nx = w_s;
    end else begin : g_in
      assign w_a      = g_stage[gi-1].g_up.r_a;
      assign w_b      = g_stage[gi-1].g_up.r_b;
      assign w_c      = g_stage[gi-1].r_c;
      assign w_v      = g_stage[gi-1].r_v;
      assign w_sum_nx = {w_s, g_stage[gi-1].r_sum};
    end

    // A stage reloads when empty or when the stage after it is taking its beat.
    if (gi == STAGES - 1) begin : g_ld
      assign w_ld = ~r_v | bus.out_ready;
    end else begin : g_ld
      assign w_ld = ~r_v | g_stage[gi+1].w_ld;
    end

    // Group P/G, then every group carry as a flat sum of products from the slice carry-in.
    always_comb begin
      logic t;
      t    = 1'b0;
      w_p  = w_a[SW-1:0] ^ w_b[SW-1:0];
      w_g  = w_a[SW-1:0] & w_b[SW-1:0];
      w_gp = '0;
      w_gg = '0;
      w_gc = '0;
      w_bc = '0;
      for (int j = 0; j < NG; j++) begin
        w_gp[j] = &w_p[4*j +: 4];
        w_gg[j] = w_g[4*j+3] | (w_p[4*j+3] & w_g[4*j+2])
                | (&w_p[4*j+2 +: 2] & w_g[4*j+1]) | (&w_p[4*j+1 +: 3] & w_g[4*j]);
      end
      for (int j = 0; j <= NG; j++) begin
        w_gc[j] = w_c;
        for (int i = 0; i < j; i++) w_gc[j] = w_gc[j] & w_gp[i];
        for (int i = 0; i < j; i++) begin
          t = w_gg[i];
          for (int m = i + 1; m < j; m++) t = t & w_gp[m];
          w_gc[j] = w_gc[j] | t;
        end
      end
      for (int j = 0; j < NG; j++) begin
        w_bc[4*j]   = w_gc[j];
        w_bc[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
        w_bc[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j]) | (&w_p[4*j +: 2] & w_gc[j]);
        w_bc[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                    | (&w_p[4*j+1 +: 2] & w_g[4*j]) | (&w_p[4*j +: 3] & w_gc[j]);
      end
      w_s = w_p ^ w_bc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_ld) begin
        r_v <= w_v;
        if (w_v) begin
          r_c   <= w_gc[NG];
          r_sum <= w_sum_nx;
        end
      end
    end

    if (gi < STAGES - 1) begin : g_up
      logic [IW-SW-1:0] r_a;
      logic [IW-SW-1:0] r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ld && w_v) begin
          r_a <= w_a[IW-1:SW];
          r_b <= w_b[IW-1:SW];
        end
      end
    end

    if (gi == STAGES - 1) begin : g_out
`ifdef CLA_PIPE_FLAGS_EN
      logic r_cmsb;
      logic r_zero;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cmsb <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_ld && w_v) begin
          r_cmsb <= w_bc[SW-1];
          r_zero <= ~|w_sum_nx;
        end
      end
      assign bus.ovf  = r_cmsb ^ r_c;
      assign bus.zero = r_zero;
`else
      assign bus.ovf  = 1'b0;
      assign bus.zero = 1'b0;
`endif
      assign bus.out_valid = r_v;
      assign bus.sum       = r_sum;
      assign bus.cout      = r_c;
    end
  end

  assign bus.in_ready = g_stage[0].w_ld;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver pushes reference results, monitor pops on each output beat.
`timescale 1ns/1ps
module tb_cla_pipe_adder;
  localparam int W = 32;
  localparam int S = 2;
`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
    int           cyc;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   lat_mode = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_pipe_adder_if #(.WIDTH(W)) bus ();
  cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic and sign rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   r;
    bb   = sub ? ~b : b;
    r    = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ^ cin);
    e.a  = a;
    e.b  = b;
    e.s  = r[W-1:0];
    e.co = r[W];
    e.ov = FL & (a[W-1] == bb[W-1]) & (r[W-1] != a[W-1]);
    e.z  = FL & (r[W-1:0] == '0);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic logic pick_ready();
    if (rdy_mode == 1) return 1'($urandom_range(0, 1));
    if (rdy_mode == 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.cin       = cin;
      bus.sub       = sub;
      bus.out_ready = pick_ready();
      #1;
      if (bus.in_ready) begin
        acc   = 1'b1;
        e.a   = a;
        e.b   = b;
        e.cyc = cyc;
        e.lat = lat_mode;
        q.push_back(e);
      end
      n++;
      if (!acc && n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready got 0 want 1 within 200 cycles");
        acc = 1'b1;
      end
    end
  endtask

  task automatic send_k(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] s, input logic co,
                        input logic ov, input logic z);
    exp_t e;
    e.s  = s;
    e.co = co;
    e.ov = ov & FL;
    e.z  = z & FL;
    send(a, b, cin, sub, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = pick_ready();
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: in_ready rule, stall stability, and in-order result checking.
  initial begin : mon
    exp_t          e;
    bit            held;
    logic [W+2:0]  hv;
    int            occ;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      occ = q.size() - ((bus.in_valid && bus.in_ready) ? 1 : 0);
      chk("in_ready", 64'(bus.in_ready), 64'(bus.out_ready || (occ < S)));
      if (held) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_hold", 64'({bus.sum, bus.cout, bus.ovf, bus.zero}), 64'(hv));
      end
      held = bus.out_valid && !bus.out_ready;
      hv   = {bus.sum, bus.cout, bus.ovf, bus.zero};
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got sum=%h want no beat", bus.sum);
        end else begin
          e = q.pop_front();
          chk("sum", 64'(bus.sum), 64'(e.s));
          chk("cout", 64'(bus.cout), 64'(e.co));
          chk("ovf", 64'(bus.ovf), 64'(e.ov));
          chk("zero", 64'(bus.zero), 64'(e.z));
          // Offered in cycle e.cyc, visible S cycles later on an unstalled pipe.
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(S));
          $display("beat a=%h b=%h -> sum=%h cout=%b ovf=%b zero=%b",
                   e.a, e.b, bus.sum, bus.cout, bus.ovf, bus.zero);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : drv
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_sum", 64'(bus.sum), 64'(0));
    chk("rst_cout", 64'(bus.cout), 64'(0));
    chk("rst_ovf", 64'(bus.ovf), 64'(0));
    chk("rst_zero", 64'(bus.zero), 64'(0));
    #11;
    rst_n = 1'b1;
    idle(2);

    lat_mode = 1'b1;
    send_k(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_k(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_k(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_k(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send_k(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_k(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    send_k(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    idle(4);

    for (int i = 0; i < 100; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    idle(4);

    lat_mode = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    rdy_mode = 0;
    for (int i = 0; i < 50 && q.size() > 0; i++) idle(1);

    // Two beats in flight, then an asynchronous reset pulse between clock edges.
    rdy_mode = 2;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0));
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1, model(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rstmid_sum", 64'(bus.sum), 64'(0));
    chk("rstmid_cout", 64'(bus.cout), 64'(0));
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(6);

    lat_mode = 1'b1;
    send_k(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    idle(2);
    chk("drain", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
